tp_product_scaler: RTL and testbench
====================================

Name: tp_product_scaler

Overview:
- Elastic two-stage pipeline directly downstream of the TrackletProcessor 16s x 11ns -> 26-bit signed multiplier.
- Consumes each raw 26-bit product and applies a round-half-up arithmetic right shift, then saturates to the tracklet-parameter word width.
- Flags whether each result lies inside the configured acceptance window. Forwards results with valid/ready flow control and a per-event saturation counter to the projection-calculation stage.

Parameters:
- PROD_W, 26, width of the signed input product.
- SHIFT, 4, right-shift applied to the product; legal range 1..12.
- OUT_W, 14, width of the signed output word.
- LIMIT, 4096, acceptance bound; out_inrange = (-LIMIT <= result <= LIMIT), evaluated after saturation.
- TAG_W, 7, width of the stub-pair tag carried alongside the data.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst  in  1  synchronous active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept an input this cycle.
- in_prod  in  PROD_W  signed product from the multiplier.
- in_tag  in  TAG_W  stub-pair tag.
- in_last  in  1  last product of the current event.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  OUT_W  rounded, saturated signed result.
- out_tag  out  TAG_W  tag, aligned with out_data.
- out_last  out  1  in_last, aligned with out_data.
- out_inrange  out  1  acceptance-window flag.
- out_sat  out  1  this word was saturated.
- sat_count  out  16  count of saturated words in the current event.
- done  out  1  one-cycle pulse when the out_last word is accepted.

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - s1_valid, s2_valid, out_valid, done and sat_count all go to 0.
  - out_data, out_tag, out_last, out_inrange and out_sat go to 0.
  - Reset mid-event discards all in-flight words; no done pulse is produced.
- Handshakes:
  - A transfer occurs when valid and ready are both 1 in the same cycle.
  - Each stage is ready when its valid is 0 or the next stage is ready.
  - in_ready = !s1_valid | s2_ready, where s2_ready = !s2_valid | out_ready. in_ready is combinational on out_ready; there is no combinational path from in_valid to out_valid.
  - A stalled stage holds its contents unchanged. Order is always preserved.
- Stage 1 (rounding):
  - r = (in_prod + 2^(SHIFT-1)) >>> SHIFT, using an arithmetic shift computed at PROD_W+1 bits so the add cannot overflow.
  - r is registered together with tag and last.
- Stage 2 (saturation and range check):
  - If r > 2^(OUT_W-1)-1, the result is 2^(OUT_W-1)-1 and sat=1.
  - If r < -2^(OUT_W-1), the result is -2^(OUT_W-1) and sat=1.
  - Otherwise the result is r and sat=0.
  - The inrange flag is computed on the saturated value. All are registered into the out_* ports; out_valid is s2_valid.
- Latency: 2 cycles from input transfer to out_valid with no backpressure. Throughput is 1 word per cycle.
- sat_count:
  - Increments on each output transfer with out_sat=1 and saturates at 0xFFFF (no wrap).
  - When the out_last word is transferred, sat_count clears to 0 on the following cycle.
  - If that last word was itself saturated, the increment is not applied.
- done: asserted for exactly one cycle, the cycle after the out_valid & out_ready & out_last transfer.
- Simultaneous events: an input transfer and an output transfer in the same cycle are both honoured with no bubble.
- Assertions:
  - Elaboration check: SHIFT must be in 1..12.
  - Bench property: inputs must be held stable while in_valid=1 & in_ready=0.

Decomposition:
- Shared package tp_scaler_pkg holds:
  - the PROD_W, OUT_W and TAG_W defaults;
  - the sat_max and sat_min constants derived from OUT_W;
  - a struct for the stage payload {data, tag, last, sat, inrange}.
- Sub-module tp_pipe_reg: one elastic register slice (valid/ready, payload hold), instantiated twice. The rounding and saturation logic stays in the top level.

Test Plan:
- Basic: in_prod=0x400, SHIFT=4, out_ready=1 -> out_data=0x040 exactly 2 cycles later, out_inrange=1, out_sat=0.
- Rounding: in_prod=24 -> 2; in_prod=-24 -> -1; in_prod=-8 -> 0; in_prod=7 -> 0.
- Saturation:
  - Stimulus: in_prod=0x1FFFFFF, then in_prod=-0x2000000, with OUT_W=14.
  - Required response: outputs 8191 then -8192, each with out_sat=1 and out_inrange=0; sat_count reads 2.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while 4 words are offered.
  - Required response: only 2 words are accepted and in_ready=0 thereafter.
  - Then out_ready=1: all 4 words emerge in order with correct tags and no duplicates or drops.
- Event end:
  - Stimulus: in_last set on the 3rd of 3 words, the 2nd of which saturates.
  - Required response: done pulses once, the cycle after the last output transfer; sat_count=1 until the last transfer and 0 one cycle later.
- Reset mid-operation:
  - Stimulus: assert ap_rst with 2 words in flight and out_ready=0.
  - Required response: out_valid=0 and sat_count=0 next cycle, and no done pulse. A fresh word after reset is processed with the 2-cycle latency.

Source files
------------

// File: rtl/tp_scaler_pkg.sv
// Shared definitions for the tracklet product scaler.
// Holds the default word widths, the saturation bounds for the output
// word, and the packed payloads carried by the two pipeline stages.
package tp_scaler_pkg;

  localparam int PROD_W_DEF = 26;
  localparam int OUT_W_DEF  = 14;
  localparam int TAG_W_DEF  = 7;

  localparam int SAT_MAX = (2 ** (OUT_W_DEF - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (OUT_W_DEF - 1));

  // Stage-1 payload: rounded product kept at PROD_W+1 bits so no
  // information from the widened rounding add is lost before saturation.
  typedef struct packed {
    logic signed [PROD_W_DEF:0] r;
    logic [TAG_W_DEF-1:0]       tag;
    logic                       last;
  } round_t;

  // Stage-2 payload: what the projection stage sees.
  typedef struct packed {
    logic signed [OUT_W_DEF-1:0] data;
    logic [TAG_W_DEF-1:0]        tag;
    logic                        last;
    logic                        sat;
    logic                        inrange;
  } stage_t;

endpackage

// File: rtl/tp_pipe_reg.sv
// One elastic register slice.
// Handshake: a word moves when valid and ready are both 1 in the same
// cycle; in_ready = !valid_q | out_ready, so the slice refills in the
// same cycle it drains and holds its word unchanged while stalled.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_data payload
//   out_valid/out_ready  downstream handshake, out_data payload (registered)
module tp_pipe_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d, data_q;

  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_valid && in_ready) ? in_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/tp_product_scaler.sv
// Rounds, saturates and range-checks multiplier products.
// Stage 1 applies a round-half-up arithmetic right shift; stage 2 clamps
// to the signed OUT_W word, flags saturation and the acceptance window.
// A per-event counter tracks saturated output words and clears after the
// event's last word leaves; done pulses the cycle after that transfer.
// Ports:
//   ap_clk, ap_rst                      clock, synchronous active-high reset
//   in_valid/in_ready, in_prod/tag/last upstream word
//   out_valid/out_ready, out_*          downstream word and flags
//   sat_count, done                     per-event saturation count, end pulse
module tp_product_scaler
  import tp_scaler_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int SHIFT  = 4,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int LIMIT  = 4096,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_prod,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_last,
  output logic              out_inrange,
  output logic              out_sat,
  output logic [15:0]       sat_count,
  output logic              done
);

  if (SHIFT < 1 || SHIFT > 12) begin : g_bad_shift
    $error("tp_product_scaler: SHIFT must be in 1..12");
  end
  // Stage payload structs are sized from the package defaults.
  if (PROD_W != PROD_W_DEF || OUT_W != OUT_W_DEF || TAG_W != TAG_W_DEF) begin : g_bad_width
    $error("tp_product_scaler: widths must match tp_scaler_pkg");
  end

  localparam logic signed [PROD_W:0] ROUND_C = (PROD_W + 1)'(2 ** (SHIFT - 1));

  logic signed [PROD_W:0]  rnd_sum;
  logic signed [PROD_W:0]  r1;
  logic signed [OUT_W-1:0] sat_data;
  round_t                  s1_in, s1_out;
  stage_t                  s2_in, s2_out;
  logic                    s1_valid, s2_ready, s2_valid;

  // Stage 1: sign-extend by one bit first so adding the half-LSB
  // constant cannot overflow at the top of the product range.
  always_comb begin
    rnd_sum    = $signed({in_prod[PROD_W-1], in_prod}) + ROUND_C;
    s1_in.r    = rnd_sum >>> SHIFT;
    s1_in.tag  = in_tag;
    s1_in.last = in_last;
  end

  tp_pipe_reg #(.W($bits(round_t))) u_s1 (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_out)
  );

  // Stage 2: clamp, then judge the window on the clamped value.
  always_comb begin
    r1 = s1_out.r;
    s2_in = '0;
    if (int'(r1) > SAT_MAX) begin
      sat_data  = OUT_W'(SAT_MAX);
      s2_in.sat = 1'b1;
    end else if (int'(r1) < SAT_MIN) begin
      sat_data  = OUT_W'(SAT_MIN);
      s2_in.sat = 1'b1;
    end else begin
      sat_data  = r1[OUT_W-1:0];
      s2_in.sat = 1'b0;
    end
    s2_in.data    = sat_data;
    s2_in.tag     = s1_out.tag;
    s2_in.last    = s1_out.last;
    s2_in.inrange = (int'(sat_data) >= -LIMIT) && (int'(sat_data) <= LIMIT);
  end

  tp_pipe_reg #(.W($bits(stage_t))) u_s2 (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (out_ready),
    .out_data  (s2_out)
  );

  assign out_valid   = s2_valid;
  assign out_data    = s2_out.data;
  assign out_tag     = s2_out.tag;
  assign out_last    = s2_out.last;
  assign out_inrange = s2_out.inrange;
  assign out_sat     = s2_out.sat;

  logic        out_xfer;
  logic [15:0] sat_count_d, sat_count_q;
  logic        done_d, done_q;

  // The last word's own saturation is not counted: the event is over.
  always_comb begin
    out_xfer    = s2_valid && out_ready;
    done_d      = out_xfer && s2_out.last;
    sat_count_d = sat_count_q;
    if (out_xfer && s2_out.last) begin
      sat_count_d = '0;
    end else if (out_xfer && s2_out.sat && (sat_count_q != 16'hFFFF)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      sat_count_q <= '0;
      done_q      <= 1'b0;
    end else begin
      sat_count_q <= sat_count_d;
      done_q      <= done_d;
    end
  end

  assign sat_count = sat_count_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tp_product_scaler.sv
module tb_tp_product_scaler;

  localparam int SHIFT = 4;
  localparam int OUT_W = 14;
  localparam int LIMIT = 4096;
  localparam longint MAXV = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OUT_W - 1));

  typedef struct packed {
    logic [13:0] data;
    logic [6:0]  tag;
    logic        last;
    logic        sat;
    logic        inrange;
  } exp_t;

  logic        ap_clk, ap_rst;
  logic        in_valid, in_ready;
  logic [25:0] in_prod;
  logic [6:0]  in_tag;
  logic        in_last;
  logic        out_valid, out_ready;
  logic [13:0] out_data;
  logic [6:0]  out_tag;
  logic        out_last, out_inrange, out_sat;
  logic [15:0] sat_count;
  logic        done;

  tp_product_scaler dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_prod     (in_prod),
    .in_tag      (in_tag),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_last    (out_last),
    .out_inrange (out_inrange),
    .out_sat     (out_sat),
    .sat_count   (sat_count),
    .done        (done)
  );

  // clock / reset
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  int   done_seen = 0;
  logic bp_rand = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: floor((p + 2^(S-1)) / 2^S), then clamp and window test.
  function automatic exp_t model(input logic [25:0] p, input logic [6:0] t, input logic l);
    longint x, d, r;
    exp_t   e;
    d = longint'(1) << SHIFT;
    x = longint'($signed(p)) + d / 2;
    r = x / d;
    if ((x % d) != 0 && x < 0) r = r - 1;
    e.sat = 1'b0;
    if (r > MAXV) begin r = MAXV; e.sat = 1'b1; end
    else if (r < MINV) begin r = MINV; e.sat = 1'b1; end
    e.data    = 14'(r);
    e.inrange = (r >= -LIMIT) && (r <= LIMIT);
    e.tag     = t;
    e.last    = l;
    return e;
  endfunction

  // scoreboard / monitor
  logic [15:0] m_cnt = '0;
  logic        m_done = 1'b0;
  logic        stall_prev = 1'b0;
  logic [25:0] prev_prod;
  logic [6:0]  prev_tag;
  logic        prev_last;

  always @(negedge ap_clk) begin
    exp_t e;
    if (ap_rst) begin
      exp_q.delete();
      m_cnt      = '0;
      m_done     = 1'b0;
      stall_prev = 1'b0;
    end else begin
      check("done", 32'(done), 32'(m_done));
      check("sat_count", 32'(sat_count), 32'(m_cnt));
      if (done) done_seen++;
      if (stall_prev) begin
        check("stable_valid", 32'(in_valid), 32'd1);
        check("stable_prod", 32'(in_prod), 32'(prev_prod));
        check("stable_tag", 32'(in_tag), 32'(prev_tag));
        check("stable_last", 32'(in_last), 32'(prev_last));
      end
      m_done = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("out_tag", 32'(out_tag), 32'(e.tag));
          check("out_last", 32'(out_last), 32'(e.last));
          check("out_sat", 32'(out_sat), 32'(e.sat));
          check("out_inrange", 32'(out_inrange), 32'(e.inrange));
          if (e.last) begin
            m_cnt  = '0;
            m_done = 1'b1;
          end else if (e.sat && m_cnt != 16'hFFFF) begin
            m_cnt = m_cnt + 16'd1;
          end
        end
      end
      stall_prev = in_valid && !in_ready;
      prev_prod  = in_prod;
      prev_tag   = in_tag;
      prev_last  = in_last;
    end
  end

  // random downstream stall generator
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (bp_rand) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send(input logic [25:0] p, input logic [6:0] t, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = p;
    in_tag   = t;
    in_last  = l;
    @(negedge ap_clk);
    while (!in_ready && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(model(p, t, l));
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge ap_clk);
      #2;
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
  endtask

  logic [25:0] bp_p[4];
  logic [25:0] rp;
  int          idx;
  int          d0;

  initial begin
    ap_rst = 1'b1; in_valid = 1'b0; in_prod = '0; in_tag = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_flags", 32'({out_tag, out_last, out_inrange, out_sat}), 32'd0);
    check("rst_sat_count", 32'(sat_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    // basic latency
    in_valid = 1'b1; in_prod = 26'h400; in_tag = 7'h01; in_last = 1'b0;
    @(negedge ap_clk);
    check("basic_in_ready", 32'(in_ready), 32'd1);
    exp_q.push_back(model(26'h400, 7'h01, 1'b0));
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    check("basic_lat1_valid", 32'(out_valid), 32'd0);
    @(posedge ap_clk);
    #1;
    check("basic_lat2_valid", 32'(out_valid), 32'd1);
    check("basic_data", 32'(out_data), 32'h40);
    check("basic_inrange", 32'(out_inrange), 32'd1);
    check("basic_sat", 32'(out_sat), 32'd0);
    wait_drain();

    // rounding
    send(26'd24, 7'h02, 1'b0);
    send(-26'sd24, 7'h03, 1'b0);
    send(-26'sd8, 7'h04, 1'b0);
    send(26'd7, 7'h05, 1'b0);
    wait_drain();

    // saturation
    send(26'h1FFFFFF, 7'h06, 1'b0);
    send(26'h2000000, 7'h07, 1'b0);
    wait_drain();
    check("sat_count_two", 32'(sat_count), 32'd2);
    send(26'd100, 7'h08, 1'b1);
    wait_drain();

    // backpressure: 4 offered, only 2 fit while stalled
    bp_p[0] = 26'd160; bp_p[1] = -26'sd320; bp_p[2] = 26'd4000; bp_p[3] = 26'h0FFFFF;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 4);
      if (idx < 4) begin
        in_prod = bp_p[idx]; in_tag = 7'(7'h10 + idx); in_last = 1'b0;
      end
      @(negedge ap_clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp_p[idx], 7'(7'h10 + idx), 1'b0));
        idx++;
      end
      @(posedge ap_clk);
      #1;
    end
    check("bp_accepted", 32'(idx), 32'd2);
    @(negedge ap_clk);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    @(posedge ap_clk);
    #1;
    out_ready = 1'b1;
    send(bp_p[2], 7'h12, 1'b0);
    send(bp_p[3], 7'h13, 1'b0);
    wait_drain();

    // event end: 2nd word saturates, 3rd is last
    send(26'd50, 7'h20, 1'b0);
    send(-26'sd9000000, 7'h21, 1'b0);
    send(26'd64, 7'h22, 1'b1);
    d0 = done_seen;
    wait_drain();
    check("evt_done", 32'(done), 32'd1);
    check("evt_sat_clear", 32'(sat_count), 32'd0);
    @(posedge ap_clk);
    #2;
    check("evt_done_once", 32'(done_seen - d0), 32'd1);

    // reset mid-operation
    send(26'h1000000, 7'h30, 1'b0);
    wait_drain();
    check("pre_rst_sat_count", 32'(sat_count), 32'd1);
    @(posedge ap_clk);
    #1;
    d0 = done_seen;
    out_ready = 1'b0;
    in_valid = 1'b1; in_prod = 26'd1000; in_tag = 7'h31; in_last = 1'b0;
    @(negedge ap_clk);
    exp_q.push_back(model(26'd1000, 7'h31, 1'b0));
    @(posedge ap_clk);
    #1;
    in_prod = 26'd2000; in_tag = 7'h32; in_last = 1'b1;
    @(negedge ap_clk);
    exp_q.push_back(model(26'd2000, 7'h32, 1'b1));
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_sat_count", 32'(sat_count), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst_mid_no_done", 32'(done_seen - d0), 32'd0);
    in_valid = 1'b1; in_prod = 26'd800; in_tag = 7'h33; in_last = 1'b0;
    @(negedge ap_clk);
    exp_q.push_back(model(26'd800, 7'h33, 1'b0));
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    check("post_rst_lat1", 32'(out_valid), 32'd0);
    @(posedge ap_clk);
    #1;
    check("post_rst_lat2", 32'(out_valid), 32'd1);
    check("post_rst_data", 32'(out_data), 32'd50);
    wait_drain();

    // randomized traffic with random downstream stalls
    bp_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: rp = 26'(int'($urandom_range(0, 400)) - 200);
        1: rp = 26'(int'($urandom_range(0, 300000)) - 150000);
        2: rp = 26'($urandom);
        default: rp = 26'(int'($urandom_range(0, 64)) - 32);
      endcase
      send(rp, 7'($urandom_range(0, 127)), ($urandom_range(0, 7) == 0));
    end
    bp_rand = 1'b0;
    #2;
    out_ready = 1'b1;
    wait_drain();
    repeat (3) @(posedge ap_clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
